// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared QPSK definitions for the mapper and demapper sides.
//   - state_e    : packer FSM states (COLLECT, HOLD, FLUSH)
//   - DIBIT_* / SYM_* : dibit values and their {real, img} sign-bit symbols
//   - qpsk_demap_f : {real, img} -> dibit
//   - qpsk_map_f   : dibit -> {real, img}
package qpsk_pkg;

  localparam int unsigned WORD_W_DEF = 21;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] DIBIT_00 = 2'b00;
  localparam logic [1:0] DIBIT_01 = 2'b01;
  localparam logic [1:0] DIBIT_10 = 2'b10;
  localparam logic [1:0] DIBIT_11 = 2'b11;

  // Symbols packed as {real, img} sign bits.
  localparam logic [1:0] SYM_00 = 2'b11;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b00;
  localparam logic [1:0] SYM_11 = 2'b10;

  // Gray-style demap: MSB is the inverted quadrature sign, LSB is real xor img.
  function automatic logic [1:0] qpsk_demap_f(input logic re, input logic im);
    return {~im, re ^ im};
  endfunction

  function automatic logic [1:0] qpsk_map_f(input logic [1:0] dibit);
    logic [1:0] sym;
    unique case (dibit)
      DIBIT_00: sym = SYM_00;
      DIBIT_01: sym = SYM_01;
      DIBIT_10: sym = SYM_10;
      default:  sym = SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/qpsk_symbol_packer_demap.sv
// qpsk_demap: combinational QPSK symbol to dibit demapper.
//   real_part_i : in-phase sign bit
//   img_part_i  : quadrature sign bit
//   dibit_o     : recovered 2-bit payload
module qpsk_demap
  import qpsk_pkg::*;
(
  input  logic       real_part_i,
  input  logic       img_part_i,
  output logic [1:0] dibit_o
);

  assign dibit_o = qpsk_demap_f(real_part_i, img_part_i);

endmodule

// File: rtl/qpsk_symbol_packer.sv
// qpsk_symbol_packer: collects NSYM QPSK symbols into one payload word.
//   clk, reset           : clock and synchronous active-high reset
//   sym_valid/sym_ready  : upstream symbol handshake, symbol on real_part/img_part
//   data_out/data_valid  : reassembled word, held until out_ready
//   out_ready            : downstream accepts data_out
//   pad_err              : discarded pad bit was 1 (valid with data_valid)
//   timeout_err          : one-cycle pulse when a partial word is dropped
module qpsk_symbol_packer
  import qpsk_pkg::*;
#(
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic              real_part,
  input  logic              img_part,
  output logic              sym_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              out_ready,
  output logic              pad_err,
  output logic              timeout_err
);

  localparam int unsigned NSYM   = (WORD_W + 1) / 2;
  localparam int unsigned BUF_W  = 2 * NSYM;
  localparam int unsigned CNT_W  = $clog2(NSYM + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [1:0]          dibit;
  logic                accept;

  qpsk_demap u_demap (
    .real_part_i (real_part),
    .img_part_i  (img_part),
    .dibit_o     (dibit)
  );

  // Outputs are forced to their idle values while reset is held, whatever the state.
  assign sym_ready   = (state_q == COLLECT) && !reset;
  assign data_valid  = (state_q == HOLD) && !reset;
  assign data_out    = data_valid ? WORD_W'(buf_q[BUF_W-1:1]) : '0;
  assign pad_err     = data_valid && buf_q[0];
  assign timeout_err = (state_q == FLUSH) && !reset;

  assign accept = sym_valid && sym_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          buf_d  = {buf_q[BUF_W-3:0], dibit};
          cnt_d  = cnt_q + CNT_W'(1);
          idle_d = '0;
          if (cnt_q == CNT_W'(NSYM - 1)) state_d = HOLD;
        end else if (cnt_q != '0) begin
          // Dropping on the cycle the count would reach TIMEOUT gives exactly
          // TIMEOUT idle cycles before the flush.
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = FLUSH;
            buf_d   = '0;
            cnt_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      FLUSH: begin
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      buf_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

endmodule
